// File: rtl/ibex_predict_tracker.sv
// ibex_predict_tracker: tracks static branch predictions from fetch until
// execute resolves them in order, and issues a registered redirect on a
// mispredict followed by a fetch hold-off window.
// Optional feature macro: IBEX_PREDICT_STATS_EN (saturating resolve and
// mispredict counters; without it the counter outputs are tied to zero).
//
// state   | meaning
// RUN     | accepting predictions while the FIFO has room
// RECOVER | post-redirect hold-off, pred_ready_o low, FIFO empty
module ibex_predict_tracker #(
    parameter int Depth         = 4,
    parameter int RecoverCycles = 2,
    parameter int CntWidth      = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pred_valid_i,
    output logic                pred_ready_o,
    input  logic                pred_taken_i,
    input  logic                pred_compressed_i,
    input  logic [31:0]         pred_pc_i,
    input  logic [31:0]         pred_target_i,
    input  logic                resolve_valid_i,
    input  logic                resolve_taken_i,
    input  logic [31:0]         resolve_target_i,
    input  logic                flush_i,
    output logic                redirect_o,
    output logic [31:0]         redirect_pc_o,
    output logic                empty_o,
    output logic                resolve_err_o,
    output logic [CntWidth-1:0] mispredict_cnt_o,
    output logic [CntWidth-1:0] resolve_cnt_o
);

    localparam int IdxW = $clog2(Depth);
    localparam int PtrW = IdxW + 1;
    localparam logic [PtrW-1:0] FullXor = {1'b1, {IdxW{1'b0}}};

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [3:0]      r_rec_cnt;
    logic [3:0]      w_rec_next;
    logic [PtrW-1:0] r_rd;
    logic [PtrW-1:0] r_wr;

    logic            r_taken  [Depth];
    logic            r_comp   [Depth];
    logic [31:0]     r_pc     [Depth];
    logic [31:0]     r_target [Depth];

    logic            r_redirect;
    logic [31:0]     r_redirect_pc;
    logic            r_err;

    logic            w_empty;
    logic            w_full;
    logic            w_enq;
    logic            w_deq;
    logic [IdxW-1:0] w_head;
    logic [IdxW-1:0] w_tail;
    logic [31:0]     w_fallthru;
    logic            w_mis;
    logic [31:0]     w_fix_pc;

    assign w_empty = (r_rd == r_wr);
    assign w_full  = ((r_rd ^ r_wr) == FullXor);
    assign w_head  = r_rd[IdxW-1:0];
    assign w_tail  = r_wr[IdxW-1:0];
    assign w_enq   = pred_valid_i & pred_ready_o;
    assign w_deq   = resolve_valid_i & ~w_empty;

    // Fall-through address wraps modulo 2^32.
    assign w_fallthru = r_pc[w_head] + (r_comp[w_head] ? 32'd2 : 32'd4);

    // Compare the oldest prediction against the actual outcome.
    always_comb begin
        w_mis    = 1'b0;
        w_fix_pc = resolve_target_i;
        if (w_deq) begin
            if (r_taken[w_head] && !resolve_taken_i) begin
                w_mis    = 1'b1;
                w_fix_pc = w_fallthru;
            end else if (!r_taken[w_head] && resolve_taken_i) begin
                w_mis = 1'b1;
            end else if (r_taken[w_head] && resolve_taken_i &&
                         (r_target[w_head] != resolve_target_i)) begin
                w_mis = 1'b1;
            end
        end
    end

    // Next-state, recovery timer and ready decode (ready from registered state only).
    always_comb begin
        w_state_next = r_state;
        w_rec_next   = r_rec_cnt;
        pred_ready_o = 1'b0;
        case (r_state)
            RUN: begin
                pred_ready_o = ~w_full;
                if (w_mis) begin
                    w_state_next = RECOVER;
                    w_rec_next   = 4'(RecoverCycles);
                end
            end
            RECOVER: begin
                if (r_rec_cnt <= 4'd1) begin
                    w_state_next = RUN;
                    w_rec_next   = 4'd0;
                end else begin
                    w_rec_next = r_rec_cnt - 4'd1;
                end
            end
            default: w_state_next = RUN;
        endcase
        if (flush_i) begin
            w_state_next = RUN;
            w_rec_next   = 4'd0;
        end
    end

    // State register and recovery down-counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= RUN;
            r_rec_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_rec_cnt <= w_rec_next;
        end
    end

    // FIFO pointers; a mispredict or flush discards everything younger.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd <= '0;
            r_wr <= '0;
        end else if (flush_i || w_mis) begin
            r_rd <= '0;
            r_wr <= '0;
        end else begin
            if (w_enq) r_wr <= r_wr + PtrW'(1);
            if (w_deq) r_rd <= r_rd + PtrW'(1);
        end
    end

    // Entry storage write on accepted prediction.
    always_ff @(posedge clk_i) begin
        if (w_enq && !w_mis && !flush_i) begin
            r_taken[w_tail]  <= pred_taken_i;
            r_comp[w_tail]   <= pred_compressed_i;
            r_pc[w_tail]     <= pred_pc_i;
            r_target[w_tail] <= pred_target_i;
        end
    end

    // Registered redirect and error pulses; flush suppresses both.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_err         <= 1'b0;
        end else begin
            r_redirect <= w_mis & ~flush_i;
            r_err      <= resolve_valid_i & w_empty & ~flush_i;
            if (w_mis && !flush_i) r_redirect_pc <= w_fix_pc;
        end
    end

    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign resolve_err_o = r_err;
    assign empty_o       = w_empty;

`ifdef IBEX_PREDICT_STATS_EN
    logic [CntWidth-1:0] r_mis_cnt;
    logic [CntWidth-1:0] r_res_cnt;

    // Saturating statistics counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mis_cnt <= '0;
            r_res_cnt <= '0;
        end else if (!flush_i) begin
            if (w_deq && (r_res_cnt != {CntWidth{1'b1}}))
                r_res_cnt <= r_res_cnt + CntWidth'(1);
            if (w_mis && (r_mis_cnt != {CntWidth{1'b1}}))
                r_mis_cnt <= r_mis_cnt + CntWidth'(1);
        end
    end

    assign mispredict_cnt_o = r_mis_cnt;
    assign resolve_cnt_o    = r_res_cnt;
`else
    assign mispredict_cnt_o = '0;
    assign resolve_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_ibex_predict_tracker.sv
// Directed bench for ibex_predict_tracker (Depth 4, RecoverCycles 2, CntWidth 4).
module tb_ibex_predict_tracker;

    localparam int CW = 4;
`ifdef IBEX_PREDICT_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          pred_valid_i;
    logic          pred_ready_o;
    logic          pred_taken_i;
    logic          pred_compressed_i;
    logic [31:0]   pred_pc_i;
    logic [31:0]   pred_target_i;
    logic          resolve_valid_i;
    logic          resolve_taken_i;
    logic [31:0]   resolve_target_i;
    logic          flush_i;
    logic          redirect_o;
    logic [31:0]   redirect_pc_o;
    logic          empty_o;
    logic          resolve_err_o;
    logic [CW-1:0] mispredict_cnt_o;
    logic [CW-1:0] resolve_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_mis = 0;
    int exp_res = 0;

    ibex_predict_tracker #(.Depth(4), .RecoverCycles(2), .CntWidth(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
        .pred_taken_i(pred_taken_i), .pred_compressed_i(pred_compressed_i),
        .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i),
        .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
        .resolve_target_i(resolve_target_i), .flush_i(flush_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .empty_o(empty_o), .resolve_err_o(resolve_err_o),
        .mispredict_cnt_o(mispredict_cnt_o), .resolve_cnt_o(resolve_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int v);
        if (!Stats) return 32'd0;
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    task automatic chk_cnt(input string tag);
        chk({tag, "_miscnt"}, 32'(mispredict_cnt_o), sat(exp_mis));
        chk({tag, "_rescnt"}, 32'(resolve_cnt_o), sat(exp_res));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic enq(input logic t, input logic c, input logic [31:0] pc, input logic [31:0] tg);
        pred_valid_i = 1'b1; pred_taken_i = t; pred_compressed_i = c;
        pred_pc_i = pc; pred_target_i = tg;
        step();
        pred_valid_i = 1'b0;
    endtask

    task automatic res(input string tag, input logic t, input logic [31:0] tg,
                       input logic exp_redir, input logic [31:0] exp_pc, input logic exp_err);
        resolve_valid_i = 1'b1; resolve_taken_i = t; resolve_target_i = tg;
        step();
        resolve_valid_i = 1'b0;
        if (!exp_err) exp_res++;
        if (exp_redir) exp_mis++;
        chk({tag, "_redir"}, 32'(redirect_o), 32'(exp_redir));
        if (exp_redir) chk({tag, "_pc"}, redirect_pc_o, exp_pc);
        chk({tag, "_err"}, 32'(resolve_err_o), 32'(exp_err));
        chk_cnt(tag);
    endtask

    initial begin
        rst_ni = 1'b0; pred_valid_i = 1'b0; pred_taken_i = 1'b0; pred_compressed_i = 1'b0;
        pred_pc_i = '0; pred_target_i = '0; resolve_valid_i = 1'b0; resolve_taken_i = 1'b0;
        resolve_target_i = '0; flush_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        chk("rst_redir", 32'(redirect_o), 32'd0);
        chk("rst_pc", redirect_pc_o, 32'd0);
        chk("rst_err", 32'(resolve_err_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_ready", 32'(pred_ready_o), 32'd1);
        chk_cnt("rst");

        // Correct taken prediction
        enq(1'b1, 1'b0, 32'h100, 32'h0F0);
        chk("t1_notempty", 32'(empty_o), 32'd0);
        res("t1", 1'b1, 32'h0F0, 1'b0, 32'h0, 1'b0);
        chk("t1_empty", 32'(empty_o), 32'd1);

        // Compressed taken resolved not-taken; 2-cycle hold-off
        enq(1'b1, 1'b1, 32'h200, 32'h280);
        res("t2", 1'b0, 32'h0, 1'b1, 32'h202, 1'b0);
        chk("t2_rdy0", 32'(pred_ready_o), 32'd0);
        step();
        chk("t2_pulse1", 32'(redirect_o), 32'd0);
        chk("t2_rdy1", 32'(pred_ready_o), 32'd0);
        step();
        chk("t2_rdy2", 32'(pred_ready_o), 32'd1);

        // Fill, full backpressure, mispredict with fetch still offering
        enq(1'b0, 1'b0, 32'h300, 32'h0);
        enq(1'b0, 1'b0, 32'h304, 32'h0);
        enq(1'b0, 1'b0, 32'h308, 32'h0);
        enq(1'b0, 1'b0, 32'h30C, 32'h0);
        chk("t3_full", 32'(pred_ready_o), 32'd0);
        pred_valid_i = 1'b1; pred_pc_i = 32'h310; pred_taken_i = 1'b0;
        res("t3", 1'b1, 32'h500, 1'b1, 32'h500, 1'b0);
        chk("t3_empty", 32'(empty_o), 32'd1);
        pred_valid_i = 1'b0;
        step(); step();
        chk("t3_empty2", 32'(empty_o), 32'd1);

        // Same-cycle enqueue dropped by mispredict when not full
        enq(1'b0, 1'b0, 32'h340, 32'h0);
        pred_valid_i = 1'b1; pred_pc_i = 32'h344;
        res("t4", 1'b1, 32'h360, 1'b1, 32'h360, 1'b0);
        pred_valid_i = 1'b0;
        chk("t4_empty", 32'(empty_o), 32'd1);
        step(); step();

        // Same-cycle enqueue and correct resolve: occupancy unchanged
        enq(1'b1, 1'b0, 32'h400, 32'h440);
        pred_valid_i = 1'b1; pred_taken_i = 1'b0; pred_pc_i = 32'h404;
        res("t5a", 1'b1, 32'h440, 1'b0, 32'h0, 1'b0);
        pred_valid_i = 1'b0;
        chk("t5_occ", 32'(empty_o), 32'd0);
        res("t5b", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t5_empty", 32'(empty_o), 32'd1);

        // Address wrap cases
        enq(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        res("t6a", 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        step(); step();
        enq(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h10);
        res("t6b", 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        step(); step();

        // Taken with wrong target
        enq(1'b1, 1'b0, 32'h800, 32'h900);
        res("t7", 1'b1, 32'h904, 1'b1, 32'h904, 1'b0);
        // Resolve during recovery (FIFO empty) flags an error
        res("t7err", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t7_rdy", 32'(pred_ready_o), 32'd0);
        step();
        chk("t7_rdy2", 32'(pred_ready_o), 32'd1);
        chk("t7_errclr", 32'(resolve_err_o), 32'd0);

        // Flush beats a mispredicting resolve
        enq(1'b1, 1'b0, 32'h600, 32'h700);
        resolve_valid_i = 1'b1; resolve_taken_i = 1'b0; flush_i = 1'b1;
        step();
        resolve_valid_i = 1'b0; flush_i = 1'b0;
        chk("t8_redir", 32'(redirect_o), 32'd0);
        chk("t8_empty", 32'(empty_o), 32'd1);
        chk("t8_ready", 32'(pred_ready_o), 32'd1);
        chk("t8_err", 32'(resolve_err_o), 32'd0);
        chk_cnt("t8");

        // Resolve while empty in RUN
        res("t9", 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t9_empty", 32'(empty_o), 32'd1);
        step();
        chk("t9_errclr", 32'(resolve_err_o), 32'd0);

        // Saturation: 20 mispredicts
        for (int i = 0; i < 20; i++) begin
            enq(1'b1, 1'b0, 32'h1000 + 32'(i * 8), 32'h2000);
            res("t10", 1'b0, 32'h0, 1'b1, 32'h1004 + 32'(i * 8), 1'b0);
            step(); step();
        end
        chk_cnt("t10_final");

        // Reset coinciding with a mispredicting resolve
        enq(1'b1, 1'b0, 32'hA00, 32'hB00);
        resolve_valid_i = 1'b1; resolve_taken_i = 1'b1; resolve_target_i = 32'hC00;
        rst_ni = 1'b0;
        step();
        resolve_valid_i = 1'b0; rst_ni = 1'b1;
        exp_mis = 0; exp_res = 0;
        chk("t11_redir", 32'(redirect_o), 32'd0);
        chk("t11_pc", redirect_pc_o, 32'd0);
        chk("t11_empty", 32'(empty_o), 32'd1);
        chk("t11_ready", 32'(pred_ready_o), 32'd1);
        chk_cnt("t11");
        step();
        chk("t11_redir2", 32'(redirect_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_predict_tracker.md
# ibex_predict_tracker

Tracks every static branch/jump prediction issued by the fetch stage until the execute stage resolves it in program order. Compares predicted vs. actual outcome and issues a registered redirect with the correct PC on mismatch. After a redirect, all younger tracked predictions are discarded and fetch is held off for a programmable recovery window. Sits between the fetch-side static predictor and the ID/EX branch-resolution logic.

## Interface
Parameters:
- Depth, 4: outstanding prediction entries; power of two, 2..16.
- RecoverCycles, 2: cycles `pred_ready_o` stays low after a redirect; 1..15.
- CntWidth, 16: width of the statistics counters.

Ports (clock and reset first):
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- pred_valid_i  in  1  fetch offers a branch/jump to track.
- pred_ready_o  out  1  tracker accepts; transfer when valid & ready.
- pred_taken_i  in  1  predicted taken.
- pred_compressed_i  in  1  instruction is 16-bit.
- pred_pc_i  in  32  instruction PC.
- pred_target_i  in  32  predicted target; ignored when not taken.
- resolve_valid_i  in  1  oldest tracked branch resolved this cycle.
- resolve_taken_i  in  1  actual direction.
- resolve_target_i  in  32  actual target, valid when taken.
- flush_i  in  1  core flush (exception/interrupt); discards all entries.
- redirect_o  out  1  one-cycle mispredict redirect pulse.
- redirect_pc_o  out  32  correct PC, valid with `redirect_o`.
- empty_o  out  1  no entries tracked.
- resolve_err_o  out  1  one-cycle pulse: resolve received while empty.
- mispredict_cnt_o  out  CntWidth  saturating mispredict count (see Configuration).
- resolve_cnt_o  out  CntWidth  saturating resolve count (see Configuration).

## Operation
- Storage: circular FIFO of Depth entries {taken, compressed, pc, target}; rd/wr pointers log2(Depth)+1 bits, wrap modulo 2·Depth; full when pointers differ only in MSB.
- States: RUN, RECOVER.
  - RUN: `pred_ready_o = !full`. Enqueue on valid & ready.
  - RUN -> RECOVER: on a mispredicting resolve. FIFO cleared (rd=wr=0); any same-cycle enqueue is dropped (younger than the branch). Recovery counter loaded with RecoverCycles.
  - RECOVER: `pred_ready_o = 0`; counter decrements each cycle; RECOVER -> RUN the cycle after it reaches 1. Resolves in RECOVER with empty FIFO raise `resolve_err_o`.
- Resolve with FIFO non-empty: pop oldest entry. Mispredict when:
  - predicted taken, actual not taken -> redirect_pc = pc + (compressed ? 2 : 4);
  - predicted not taken, actual taken -> redirect_pc = resolve_target_i;
  - both taken, target != resolve_target_i -> redirect_pc = resolve_target_i.
- Address arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 = 0x0000_0000.
- Simultaneous enqueue+resolve when full: ready is low (no combinational path from resolve to ready); the resolve proceeds.
- Simultaneous enqueue+resolve, not full, correct prediction: both happen, occupancy unchanged.
- flush_i: highest priority. Clears FIFO, forces RUN, clears recovery counter, suppresses any redirect and error for that cycle. Counters are not cleared.
- Resolve while empty in RUN: no pop, no redirect, `resolve_err_o` pulse.

## Timing
- Reset (rst_ni low at edge): FIFO empty, state RUN, `redirect_o=0`, `redirect_pc_o=0`, `resolve_err_o=0`, counters 0. `pred_ready_o=1`, `empty_o=1` from the first cycle after reset.
- `redirect_o`, `redirect_pc_o`, `resolve_err_o` are registered: asserted the cycle after the resolve edge, for exactly one cycle.
- `pred_ready_o` is low from the cycle after the mispredict edge for RecoverCycles cycles.
- `empty_o` and `pred_ready_o` are decoded from registered state only.
- Reset mid-recovery or mid-redirect: all state is dropped; a pending redirect pulse is not emitted.

## Configuration
- `IBEX_PREDICT_STATS_EN` defined: two CntWidth saturating counters. resolve_cnt increments on every non-empty resolve; mispredict_cnt increments on each redirect. Both hold at all-ones.
- Macro undefined: no counter flops; `mispredict_cnt_o` and `resolve_cnt_o` tied to 0.

## Test plan
- Enqueue taken pc=0x100 target=0x0F0 (uncompressed); resolve taken, target 0x0F0 -> no redirect, `empty_o=1` next cycle, resolve_cnt=1.
- Enqueue taken compressed pc=0x200; resolve not-taken -> next cycle `redirect_o=1`, `redirect_pc_o=0x202`; `pred_ready_o=0` for 2 cycles, then 1.
- Fill 4 entries; 5th valid sees ready=0. Resolve the oldest as mispredicted while `pred_valid_i=1` -> FIFO empty, the new entry is dropped, mispredict_cnt=1.
- Enqueue not-taken pc=0xFFFF_FFFC; resolve taken target=0x80 -> `redirect_pc_o=0x80`. Separately, a predicted-taken entry at that pc resolved not-taken -> `redirect_pc_o=0x0`.
- Mispredicting resolve and `flush_i` in the same cycle -> no redirect, FIFO empty, state RUN, ready=1 next cycle.
- Resolve while empty -> `resolve_err_o` pulses one cycle and no counter changes. With `IBEX_PREDICT_STATS_EN` and CntWidth=4, 20 mispredicts -> mispredict_cnt stays at 15.
